// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot pipeline.
// Coordinates are 4.23 two's-complement fixed point.
package mandel_pkg;

  localparam int COORD_W   = 27;
  localparam int FRAC_W    = 23;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pixel_coord_gen.sv
// Raster walker emitting one 4.23 complex coordinate per pixel to the iterator.
// Latency: start -> first out_val one cycle; one pixel per clock at sustained out_rdy.
// Backpressure: outputs hold while out_val && !out_rdy. Optional PIXEL_COORD_GEN_PERF_EN adds frame_cycles.
module pixel_coord_gen
  import mandel_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int COL_START  = 0,
  parameter int COL_STRIDE = 1,
  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1,
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] r_start,
  input  logic [COORD_W-1:0] i_start,
  input  logic [COORD_W-1:0] dx,
  input  logic [COORD_W-1:0] dy,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [COORD_W-1:0] out_c_r,
  output logic [COORD_W-1:0] out_c_i,
  output logic [X_W-1:0]     out_x,
  output logic [Y_W-1:0]     out_y,
`ifdef PIXEL_COORD_GEN_PERF_EN
  output logic [31:0]        frame_cycles,
`endif
  output logic               busy,
  output logic               done
);

  // A start column past the right edge yields an empty frame.
  localparam bit             EMPTY   = (COL_START >= H_RES);
  localparam logic [X_W-1:0] X_FIRST = X_W'(COL_START);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_RES - 1);

  state_t state;
  coord_t r_start_q;
  coord_t dx_q;
  coord_t dy_q;

  logic        fire;
  logic [31:0] x_sum;
  logic        row_end;
  logic        last_row;
  logic        launch;

  assign fire     = (state == RUN) && out_val && out_rdy;
  assign x_sum    = 32'(out_x) + 32'(COL_STRIDE);
  assign row_end  = (x_sum >= 32'(H_RES));
  assign last_row = (out_y == Y_LAST);
  assign launch   = (state == IDLE) && start && !abort && !EMPTY;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_val   <= 1'b0;
      out_c_r   <= '0;
      out_c_i   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      r_start_q <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (EMPTY) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              out_val   <= 1'b1;
              r_start_q <= r_start;
              dx_q      <= dx;
              dy_q      <= dy;
              out_c_r   <= r_start;
              out_c_i   <= i_start;
              out_x     <= X_FIRST;
              out_y     <= '0;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            out_val <= 1'b0;
            busy    <= 1'b0;
          end else if (fire) begin
            if (!row_end) begin
              out_x   <= X_W'(x_sum);
              out_c_r <= out_c_r + dx_q;
            end else if (!last_row) begin
              out_x   <= X_FIRST;
              out_c_r <= r_start_q;
              out_y   <= out_y + 1'b1;
              out_c_i <= out_c_i - dy_q;
            end else begin
              state   <= IDLE;
              out_val <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIXEL_COORD_GEN_PERF_EN
  // Counts every RUN cycle; left untouched in IDLE so software can read it back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cycles <= '0;
    end else if (launch) begin
      frame_cycles <= '0;
    end else if (state == RUN && !abort) begin
      frame_cycles <= frame_cycles + 32'd1;
    end
  end
`endif

endmodule
